controle_de_carga: RTL and testbench
====================================

# controle_de_carga

Program-load and run sequencer for the processor's instruction memory. Accepts a program from a host as a byte stream with a valid/ready handshake, packs it into 32-bit instruction words and writes them into consecutive instruction-memory addresses. It holds the processor in reset while loading, releases it to run, and regains control when the processor reports a halt. It also owns the instruction-memory address mux, choosing between the write pointer during load and the processor PC during run.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction-memory address width
- START_ADDR, 1, address of the first loaded word
- MAX_WORDS, 150, maximum words per program

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- host_start  in  1  request a new load; honoured only in IDLE or HALT
- host_valid  in  1  host_byte is valid
- host_byte  in  8  program byte
- host_last  in  1  qualifies the final byte of the program
- host_ready  out  1  byte accepted when host_valid && host_ready
- mem_we  out  1  instruction-memory write strobe, one cycle per word
- mem_addr  out  ADDR_WIDTH  instruction-memory address
- mem_wdata  out  32  instruction word to write
- cpu_pc  in  32  processor fetch address
- cpu_halt  in  1  processor executed halt; sampled only in RUN
- cpu_reset  out  1  processor reset, held high except in RUN
- cpu_run  out  1  high in RUN
- word_count  out  ADDR_WIDTH  words written by the current/last load
- load_error  out  1  sticky error flag, cleared by an accepted host_start

## Operation
- States: IDLE, LOAD, START, RUN, HALT.
- IDLE/HALT: an accepted host_start moves to LOAD. On entry, the write pointer is set to START_ADDR, the byte index and word_count are set to 0, and load_error is cleared.
- LOAD: host_ready=1. Bytes are packed big-endian: byte 0 goes to bits[31:24] (opcode first) and byte 3 to bits[7:0].
- Fourth byte accepted: the word is registered onto mem_wdata, mem_we=1 for the next cycle, the pointer increments after the write, word_count increments, and the byte index wraps to 0.
- host_last on a 4th byte: the word is written and the state goes to START.
- host_last on byte index 0–2: load_error=1, the partial word is discarded with no mem_we, and the state goes to IDLE.
- Overflow: a byte accepted with word_count==MAX_WORDS and byte index 0 sets load_error=1, with no write, and the state goes to IDLE.
- START: exactly one cycle, with cpu_reset still 1, so the final write completes; then RUN.
- RUN: cpu_reset=0, cpu_run=1, host_ready=0. cpu_halt=1 moves to HALT. host_start is ignored.
- HALT: cpu_reset=1, cpu_run=0. mem_addr and word_count are preserved.
- cpu_halt and host_start both high in RUN: the halt is taken and the start is ignored (it must be re-asserted in HALT).
- host_start during LOAD or START is ignored. cpu_halt outside RUN is ignored.
- mem_addr is combinational: cpu_pc[ADDR_WIDTH-1:0] in RUN, otherwise the registered write pointer.
- mem_addr width rule: cpu_pc upper bits are ignored, so the address wraps modulo 2^ADDR_WIDTH.
- Write-pointer width rule: the pointer never wraps, because the overflow check fires first.

## Timing
- Reset values: IDLE, host_ready=0, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, cpu_reset=1, cpu_run=0, word_count=0, load_error=0.
- Reset is asynchronous. Asserting it mid-load aborts the load immediately, and no further mem_we occurs.
- host_ready is decoded from the state register only; it does not depend on host_valid combinationally.
- Fourth byte accepted at edge N: during cycle N..N+1, mem_we=1 with mem_addr and mem_wdata stable; the pointer advances at edge N+1.
- Final byte accepted at edge N: START during N..N+1; RUN (cpu_reset=0) from edge N+1; the processor's first fetch is at START_ADDR.
- cpu_halt sampled high at edge M: cpu_reset=1 and cpu_run=0 from edge M.
- A back-to-back host stream sustains 1 byte per cycle, i.e. 1 word per 4 cycles.

## Test plan
- Reset check: assert reset for 3 cycles → every output equals its reset value; host_ready=0 even with host_valid=1.
- Two-word load: host_start, then bytes A0 00 00 00 C0 80 00 03 with host_last on the 8th → writes addr1=0xA0000000 and addr2=0xC0800003, one mem_we each; word_count=2; cpu_reset falls 2 edges after the last byte; mem_addr follows cpu_pc.
- Short program: 3 bytes with host_last on the 3rd → load_error=1, state IDLE, zero mem_we pulses; the next host_start clears load_error.
- Overflow with MAX_WORDS=2: 9 bytes streamed → 2 writes, load_error=1 on the 9th byte, state IDLE, cpu_reset stays 1.
- Halt and reload: in RUN, drive cpu_halt and host_start together → HALT with start ignored; host_start again → LOAD, mem_addr=1, word_count=0.
- Reset mid-word: reset asserted after 2 bytes → IDLE asynchronously with no mem_we; a fresh load afterwards writes a correct word at addr 1.

Source files
------------

// File: rtl/controle_de_carga.sv
// Program loader/run sequencer: packs host bytes big-endian into 32-bit words for instruction memory, then runs the CPU until halt.
// Latency: word write strobe one cycle after its 4th byte; RUN one cycle after the final write. host_ready is high only in LOAD.
module controle_de_carga #(
    parameter int ADDR_WIDTH = 10,
    parameter int START_ADDR = 1,
    parameter int MAX_WORDS  = 150
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  host_start,
    input  logic                  host_valid,
    input  logic [7:0]            host_byte,
    input  logic                  host_last,
    output logic                  host_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           cpu_pc,
    input  logic                  cpu_halt,
    output logic                  cpu_reset,
    output logic                  cpu_run,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  load_error
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, HALT} state_t;

    localparam logic [ADDR_WIDTH-1:0] START_PTR = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           shift_q, shift_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;

    logic pc_unused;
    assign pc_unused = ^cpu_pc[31:ADDR_WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= START_PTR;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = err_q;

        // The pointer advances only after the strobe cycle so address and data stay aligned.
        if (we_q) begin
            ptr_d = ptr_q + ONE;
        end

        unique case (state_q)
            IDLE, HALT: begin
                if (host_start) begin
                    state_d = LOAD;
                    ptr_d   = START_PTR;
                    cnt_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (host_valid) begin
                    if (idx_q == 2'd0 && cnt_q == MAX_CNT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (idx_q == 2'd3) begin
                        wdata_d = {shift_q, host_byte};
                        we_d    = 1'b1;
                        cnt_d   = cnt_q + ONE;
                        idx_d   = '0;
                        if (host_last) begin
                            state_d = START;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], host_byte};
                        idx_d   = idx_q + 2'd1;
                        if (host_last) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (cpu_halt) begin
                    state_d = HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign host_ready = (state_q == LOAD);
    assign cpu_run    = (state_q == RUN);
    assign cpu_reset  = (state_q != RUN);
    assign mem_addr   = (state_q == RUN) ? cpu_pc[ADDR_WIDTH-1:0] : ptr_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign word_count = cnt_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_controle_de_carga.sv
// Bench for controle_de_carga: directed vector table, async-reset corners, and random programs scored against a byte-list model.
module tb_controle_de_carga;

    localparam int AW      = 10;
    localparam int START_A = 1;
    localparam int MAXW    = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          host_start, host_valid, host_last, host_ready;
    logic [7:0]    host_byte;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   cpu_pc;
    logic          cpu_halt, cpu_reset, cpu_run, load_error;
    logic [AW-1:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    controle_de_carga #(.ADDR_WIDTH(AW), .START_ADDR(START_A), .MAX_WORDS(MAXW)) dut (
        .clock(clock), .reset(reset),
        .host_start(host_start), .host_valid(host_valid), .host_byte(host_byte),
        .host_last(host_last), .host_ready(host_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_pc(cpu_pc), .cpu_halt(cpu_halt), .cpu_reset(cpu_reset), .cpu_run(cpu_run),
        .word_count(word_count), .load_error(load_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic we,
                           input logic [AW-1:0] addr, input logic [31:0] wd,
                           input logic rst, input logic run,
                           input logic [AW-1:0] cnt, input logic err);
        chk({tag, ".host_ready"}, 32'(host_ready), 32'(rdy));
        chk({tag, ".mem_we"},     32'(mem_we),     32'(we));
        chk({tag, ".mem_addr"},   32'(mem_addr),   32'(addr));
        chk({tag, ".mem_wdata"},  mem_wdata,       wd);
        chk({tag, ".cpu_reset"},  32'(cpu_reset),  32'(rst));
        chk({tag, ".cpu_run"},    32'(cpu_run),    32'(run));
        chk({tag, ".word_count"}, 32'(word_count), 32'(cnt));
        chk({tag, ".load_error"}, 32'(load_error), 32'(err));
    endtask

    // Reference: a program of len bytes yields floor(len/4) words unless it overflows MAXW;
    // success only when len is a whole number of words within the limit.
    task automatic run_program(input int len);
        logic [7:0] b[$];
        int consumed, nexp, budget, i;
        bit ok, acc;
        logic [31:0] pc;
        for (int k = 0; k < len; k++) b.push_back(8'($urandom_range(0, 255)));
        if (len > 4 * MAXW) begin
            consumed = 4 * MAXW + 1; nexp = MAXW; ok = 0;
        end else begin
            consumed = len; nexp = len / 4; ok = (len % 4 == 0);
        end
        wa_q.delete(); wd_q.delete();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        chk("entry.host_ready", 32'(host_ready), 32'd1);
        chk("entry.word_count", 32'(word_count), 32'd0);
        chk("entry.load_error", 32'(load_error), 32'd0);
        chk("entry.mem_addr",   32'(mem_addr),   32'(START_A));
        i = 0; budget = 0;
        while (i < consumed && budget < 200) begin
            host_valid = ($urandom_range(0, 3) != 0);
            host_byte  = b[i];
            host_last  = (i == len - 1);
            acc = host_valid && host_ready;
            step();
            if (acc) i++;
            budget++;
        end
        host_valid = 1'b0; host_last = 1'b0;
        chk("stream.accepted", 32'(i), 32'(consumed));
        if (ok) begin
            chk("start.cpu_reset", 32'(cpu_reset), 32'd1);
            chk("start.mem_we",    32'(mem_we),    32'd1);
            step();
            chk("run.cpu_reset", 32'(cpu_reset), 32'd0);
            chk("run.cpu_run",   32'(cpu_run),   32'd1);
        end else begin
            chk("err.load_error", 32'(load_error), 32'd1);
            chk("err.host_ready", 32'(host_ready), 32'd0);
            chk("err.cpu_reset",  32'(cpu_reset),  32'd1);
            step();
            chk("err.cpu_run", 32'(cpu_run), 32'd0);
        end
        chk("writes.count", 32'(wa_q.size()), 32'(nexp));
        for (int k = 0; k < nexp && k < wa_q.size(); k++) begin
            chk("writes.addr", 32'(wa_q[k]), 32'(START_A + k));
            chk("writes.data", wd_q[k], {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
        end
        chk("word_count", 32'(word_count), 32'(nexp));
        if (ok) begin
            repeat (3) begin
                pc = $urandom;
                cpu_pc = pc;
                #1;
                chk("run.pc_mux", 32'(mem_addr), pc % 1024);
                step();
            end
            cpu_halt   = 1'b1;
            host_start = 1'($urandom_range(0, 1));
            step();
            cpu_halt = 1'b0; host_start = 1'b0;
            chk("halt.cpu_reset",  32'(cpu_reset),  32'd1);
            chk("halt.cpu_run",    32'(cpu_run),    32'd0);
            chk("halt.host_ready", 32'(host_ready), 32'd0);
            chk("halt.mem_addr",   32'(mem_addr),   32'(START_A + nexp));
            chk("halt.word_count", 32'(word_count), 32'(nexp));
        end
    endtask

    typedef struct {
        logic        st, vl;
        logic [7:0]  by;
        logic        ls, hl;
        logic [31:0] pc;
        logic        e_rdy, e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_wd;
        logic        e_rst, e_run;
        logic [9:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //         st vl  by    ls hl pc            rdy we addr wdata         rst run cnt err
        tbl[0]  = '{1, 0, 8'h00, 0, 0, 32'h0,        1, 0, 1, 32'h00000000, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 8'hA0, 0, 0, 32'h0,        1, 0, 1, 32'h00000000, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 8'h00, 0, 1, 32'h0,        1, 0, 1, 32'h00000000, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 8'h00, 0, 0, 32'h0,        1, 0, 1, 32'h00000000, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 8'h00, 0, 0, 32'h0,        1, 1, 1, 32'hA0000000, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 8'hFF, 0, 0, 32'h0,        1, 0, 2, 32'hA0000000, 1, 0, 1, 0};
        tbl[6]  = '{0, 1, 8'hC0, 0, 0, 32'h0,        1, 0, 2, 32'hA0000000, 1, 0, 1, 0};
        tbl[7]  = '{0, 1, 8'h80, 0, 0, 32'h0,        1, 0, 2, 32'hA0000000, 1, 0, 1, 0};
        tbl[8]  = '{0, 1, 8'h00, 0, 0, 32'h0,        1, 0, 2, 32'hA0000000, 1, 0, 1, 0};
        tbl[9]  = '{0, 1, 8'h03, 1, 0, 32'h0,        0, 1, 2, 32'hC0800003, 1, 0, 2, 0};
        tbl[10] = '{0, 0, 8'h00, 0, 0, 32'h1,        0, 0, 1, 32'hC0800003, 0, 1, 2, 0};
        tbl[11] = '{0, 0, 8'h00, 0, 0, 32'hFFFFF405, 0, 0, 5, 32'hC0800003, 0, 1, 2, 0};
        tbl[12] = '{1, 0, 8'h00, 0, 1, 32'h5,        0, 0, 3, 32'hC0800003, 1, 0, 2, 0};
        tbl[13] = '{0, 0, 8'h00, 0, 1, 32'h5,        0, 0, 3, 32'hC0800003, 1, 0, 2, 0};
        tbl[14] = '{1, 0, 8'h00, 0, 0, 32'h5,        1, 0, 1, 32'hC0800003, 1, 0, 0, 0};
        tbl[15] = '{0, 1, 8'h11, 1, 0, 32'h5,        0, 0, 1, 32'hC0800003, 1, 0, 0, 1};
        tbl[16] = '{1, 0, 8'h00, 0, 0, 32'h5,        1, 0, 1, 32'hC0800003, 1, 0, 0, 0};

        reset = 1'b1; host_start = 1'b0; host_valid = 1'b1; host_byte = 8'h5A;
        host_last = 1'b0; cpu_pc = '0; cpu_halt = 1'b0;
        repeat (3) step();
        chk_all("reset", 0, 0, 1, 32'h0, 1, 0, 0, 0);
        reset = 1'b0; host_valid = 1'b0;
        step();
        chk_all("idle", 0, 0, 1, 32'h0, 1, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            host_start = tbl[i].st; host_valid = tbl[i].vl; host_byte = tbl[i].by;
            host_last  = tbl[i].ls; cpu_halt   = tbl[i].hl; cpu_pc    = tbl[i].pc;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wd,
                    tbl[i].e_rst, tbl[i].e_run, tbl[i].e_cnt, tbl[i].e_err);
        end
        host_start = 1'b0; cpu_halt = 1'b0; host_last = 1'b0;

        // Two bytes into a word, then an asynchronous reset between edges.
        host_valid = 1'b1; host_byte = 8'h12; step();
        host_byte = 8'h34; step();
        host_valid = 1'b0;
        wa_q.delete(); wd_q.delete();
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 1, 32'h0, 1, 0, 0, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) step();
        chk("async_reset.no_we", 32'(wa_q.size()), 32'd0);

        run_program(4);
        run_program(9);
        run_program(8);
        run_program(3);
        for (int n = 0; n < 40; n++) run_program($urandom_range(1, 10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
